stack_id_negotiator: RTL and testbench

- Parametrised successor to the 3D-stack self-test / ID-sort block.
- Each die in the stack gets a chip ID and a power value through a shared inter-layer word bus, synchronised by a 16-bit sync pattern.
- Adds over the previous generation:
  - configurable ID, power and timeout widths;
  - an explicit top-of-stack result;
  - ID-overflow handling;
  - invalid-frame rejection.
- One instance per die, clocked by div_8_clk.

---
 rtl/stack_id_negotiator.sv | 161 ++++++++++++++++
 tb/tb_stack_id_negotiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_id_negotiator.sv
// Per-die chip-ID / power negotiation over the shared inter-layer word bus.
// Optional STACK_PARITY_EN: even frame parity carried in hdr[0], checked on receive.
module stack_id_negotiator #(
    parameter int              ID_W     = 4,
    parameter int              PWR_W    = 4,
    parameter int              TIMEOUT  = 20,
    parameter logic [PWR_W-1:0] PWR_INIT = '0,
    parameter logic [15:0]     SYNC     = 16'hBEEF,
    localparam int             DATA_W   = 4 + PWR_W + 2*ID_W + 16
) (
    input  logic              div_8_clk,
    input  logic              rst_n,
    input  logic              f_layer,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ID_W-1:0]   chip_id,
    output logic [PWR_W-1:0]  power_value,
    output logic              sort_finish,
    output logic              top_of_stack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  FIRST_ID = ID_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_WAIT = 3'd1,
        TX      = 3'd2,
        RX_ACK  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   chip_id_nxt;
    logic [PWR_W-1:0]  power_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              tos_nxt;

    function automatic logic [PWR_W-1:0] pwr_sat_inc(input logic [PWR_W-1:0] v);
        return (&v) ? v : v + PWR_W'(1);
    endfunction

    function automatic logic frame_par(input logic [DATA_W-1:0] f);
        return ^f;
    endfunction

    logic [ID_W-1:0]   id_inc;
    logic [PWR_W-1:0]  rx_pwr;
    logic [ID_W-1:0]   rx_src;
    logic [ID_W-1:0]   rx_dst;
    logic              sync_ok;
    logic              frame_vld;
    logic [DATA_W-1:0] tx_frame;

    assign id_inc  = chip_id + ID_W'(1);
    assign rx_pwr  = data_in[DATA_W-5 -: PWR_W];
    assign rx_src  = data_in[16+2*ID_W-1 -: ID_W];
    assign rx_dst  = data_in[16+ID_W-1 -: ID_W];
    assign sync_ok = (data_in[15:0] == SYNC);

`ifdef STACK_PARITY_EN
    // hdr[0] is chosen so the whole transmitted word has even parity
    assign frame_vld = sync_ok && !frame_par(data_in);
    assign tx_frame  = {3'b101,
                        frame_par({3'b101, 1'b0, power_value, chip_id, id_inc, SYNC}),
                        power_value, chip_id, id_inc, SYNC};
`else
    logic [3:0] unused_hdr;
    assign unused_hdr = data_in[DATA_W-1 -: 4];
    assign frame_vld  = sync_ok;
    assign tx_frame   = {4'b1010, power_value, chip_id, id_inc, SYNC};
`endif

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            chip_id      <= '0;
            power_value  <= '0;
            cnt          <= '0;
            top_of_stack <= 1'b0;
        end else begin
            state        <= state_nxt;
            chip_id      <= chip_id_nxt;
            power_value  <= power_nxt;
            cnt          <= cnt_nxt;
            top_of_stack <= tos_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        chip_id_nxt = chip_id;
        power_nxt   = power_value;
        cnt_nxt     = cnt;
        tos_nxt     = top_of_stack;
        case (state)
            IDLE: begin
                if (f_layer) begin
                    chip_id_nxt = FIRST_ID;
                    power_nxt   = PWR_INIT;
                    if (&FIRST_ID) begin
                        state_nxt = DONE;
                        tos_nxt   = 1'b1;
                    end else begin
                        state_nxt = TX;
                        cnt_nxt   = '0;
                    end
                end else begin
                    state_nxt = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (frame_vld && (rx_dst != '0)) begin
                    chip_id_nxt = rx_dst;
                    power_nxt   = rx_pwr;
                    // An all-ones ID has no successor to announce: this die is the top
                    if (&rx_dst) begin
                        state_nxt = DONE;
                        tos_nxt   = 1'b1;
                    end else begin
                        state_nxt = TX;
                        cnt_nxt   = '0;
                    end
                end
            end
            TX: begin
                state_nxt = RX_ACK;
                cnt_nxt   = '0;
            end
            RX_ACK: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (frame_vld && (rx_src == id_inc)) begin
                    state_nxt = DONE;
                    tos_nxt   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    if (&power_value) begin
                        state_nxt = DONE;
                        tos_nxt   = 1'b1;
                    end else begin
                        power_nxt = pwr_sat_inc(power_value);
                        state_nxt = TX;
                        cnt_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tx_out      = (state == TX);
    assign data_out    = tx_out ? tx_frame : '0;
    assign sort_finish = (state == DONE);

endmodule

// File: tb/tb_stack_id_negotiator.sv
// Scoreboard bench for stack_id_negotiator at default parameters (32-bit frames).
module tb_stack_id_negotiator;

    logic        div_8_clk;
    logic        rst_n;
    logic        f_layer;
    logic [31:0] data_in;
    logic        tx_out;
    logic [31:0] data_out;
    logic [3:0]  chip_id;
    logic [3:0]  power_value;
    logic        sort_finish;
    logic        top_of_stack;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    stack_id_negotiator dut (
        .div_8_clk    (div_8_clk),
        .rst_n        (rst_n),
        .f_layer      (f_layer),
        .data_in      (data_in),
        .tx_out       (tx_out),
        .data_out     (data_out),
        .chip_id      (chip_id),
        .power_value  (power_value),
        .sort_finish  (sort_finish),
        .top_of_stack (top_of_stack)
    );

    initial div_8_clk = 1'b0;
    always #5 div_8_clk = ~div_8_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge div_8_clk);
    endtask

    // Frame with standard header; under parity builds hdr[0] makes total parity even
    function automatic logic [31:0] mk_frame(input logic [3:0] pwr, input logic [3:0] src,
                                             input logic [3:0] dst);
        logic [31:0] f;
        f = {4'b1010, pwr, src, dst, 16'hBEEF};
`ifdef STACK_PARITY_EN
        f[28] = ^f;
`endif
        return f;
    endfunction

    task automatic apply_reset(input logic fl);
        rst_n   = 1'b0;
        data_in = '0;
        tick(2);
        f_layer = fl;
        rst_n   = 1'b1;
    endtask

    // Every TX cycle must match the next queued frame
    always @(negedge div_8_clk) begin
        if (tx_out === 1'b1) begin
            if (exp_q.size() == 0)
                check_val("tx_unexpected", 64'(tx_out), 64'd0);
            else
                check_val("tx_frame", 64'(data_out), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        f_layer = 1'b0;
        data_in = '0;
        tick(2);
        check_val("rst_chip_id", 64'(chip_id), 64'd0);
        check_val("rst_power", 64'(power_value), 64'd0);
        check_val("rst_tx_out", 64'(tx_out), 64'd0);
        check_val("rst_data_out", 64'(data_out), 64'd0);
        check_val("rst_sort", 64'(sort_finish), 64'd0);
        check_val("rst_tos", 64'(top_of_stack), 64'd0);

        // First layer, nobody answers: power climbs 0..F then gives up
        f_layer = 1'b1;
        rst_n   = 1'b1;
        exp_q.push_back(mk_frame(4'h0, 4'h1, 4'h2));
        tick(1);
        check_val("fl_tx_first", 64'(tx_out), 64'd1);
        for (int p = 1; p < 16; p++) begin
            tick(20);
            check_val("fl_gap", 64'(tx_out), 64'd0);
            exp_q.push_back(mk_frame(4'(p), 4'h1, 4'h2));
            tick(1);
            check_val("fl_retry_tx", 64'(tx_out), 64'd1);
            check_val("fl_retry_pwr", 64'(power_value), 64'(p));
        end
        tick(21);
        check_val("fl_done_sort", 64'(sort_finish), 64'd1);
        check_val("fl_done_tos", 64'(top_of_stack), 64'd1);
        check_val("fl_done_id", 64'(chip_id), 64'd1);
        check_val("fl_done_pwr", 64'(power_value), 64'hF);
        check_val("fl_done_tx", 64'(tx_out), 64'd0);

        // Upper layer join, ack in RX_ACK cycle 4
        apply_reset(1'b0);
        tick(1);
        data_in = 32'hA523_0000;
        tick(1);
        check_val("ul_badsync_id", 64'(chip_id), 64'd0);
        check_val("ul_badsync_tx", 64'(tx_out), 64'd0);
        data_in = mk_frame(4'h5, 4'h2, 4'h3);
        exp_q.push_back(mk_frame(4'h5, 4'h3, 4'h4));
        tick(1);
        check_val("ul_tx", 64'(tx_out), 64'd1);
        check_val("ul_id", 64'(chip_id), 64'd3);
        check_val("ul_pwr", 64'(power_value), 64'd5);
        data_in = '0;
        tick(2);
        data_in = mk_frame(4'h6, 4'h5, 4'h5);
        tick(1);
        data_in = '0;
        tick(2);
        check_val("ul_wrong_src", 64'(sort_finish), 64'd0);
        data_in = mk_frame(4'h6, 4'h4, 4'h5);
        tick(1);
        check_val("ul_ack_sort", 64'(sort_finish), 64'd1);
        check_val("ul_ack_tos", 64'(top_of_stack), 64'd0);
        check_val("ul_ack_dout", 64'(data_out), 64'd0);
        data_in = '0;

        // Ack arriving on the timeout cycle beats the retry
        apply_reset(1'b0);
        tick(1);
        data_in = mk_frame(4'h7, 4'h1, 4'h2);
        exp_q.push_back(mk_frame(4'h7, 4'h2, 4'h3));
        tick(1);
        check_val("to_tx", 64'(tx_out), 64'd1);
        data_in = '0;
        tick(20);
        check_val("to_pre_tx", 64'(tx_out), 64'd0);
        data_in = mk_frame(4'h0, 4'h3, 4'h0);
        tick(1);
        check_val("to_ack_sort", 64'(sort_finish), 64'd1);
        check_val("to_ack_tos", 64'(top_of_stack), 64'd0);
        check_val("to_ack_pwr", 64'(power_value), 64'd7);
        data_in = '0;
        tick(3);
        check_val("to_no_retry", 64'(tx_out), 64'd0);

        // ID overflow: dst_id all-ones
        apply_reset(1'b0);
        tick(1);
        data_in = mk_frame(4'h0, 4'hE, 4'hF);
        tick(1);
        check_val("ov_id", 64'(chip_id), 64'hF);
        check_val("ov_tx", 64'(tx_out), 64'd0);
        check_val("ov_sort", 64'(sort_finish), 64'd1);
        check_val("ov_tos", 64'(top_of_stack), 64'd1);
        data_in = '0;
        tick(2);

        // Invalid frames are ignored in RX_WAIT
        apply_reset(1'b0);
        tick(1);
        data_in = mk_frame(4'h0, 4'h1, 4'h0);
        tick(3);
        check_val("inv_dst0_id", 64'(chip_id), 64'd0);
        check_val("inv_dst0_tx", 64'(tx_out), 64'd0);
        check_val("inv_dst0_sort", 64'(sort_finish), 64'd0);
`ifdef STACK_PARITY_EN
        data_in = mk_frame(4'h9, 4'h2, 4'h4) ^ 32'h1000_0000;
        tick(2);
        check_val("inv_par_id", 64'(chip_id), 64'd0);
        check_val("inv_par_tx", 64'(tx_out), 64'd0);
`endif
        data_in = mk_frame(4'h9, 4'h2, 4'h4);
        exp_q.push_back(mk_frame(4'h9, 4'h4, 4'h5));
        tick(1);
        check_val("ok_tx", 64'(tx_out), 64'd1);
        check_val("ok_id", 64'(chip_id), 64'd4);
        check_val("ok_pwr", 64'(power_value), 64'd9);
        data_in = '0;

        // Asynchronous reset in RX_ACK cycle 7, then a clean restart
        tick(8);
        check_val("ar_pre_id", 64'(chip_id), 64'd4);
        rst_n = 1'b0;
        #1;
        check_val("ar_id", 64'(chip_id), 64'd0);
        check_val("ar_pwr", 64'(power_value), 64'd0);
        check_val("ar_tx", 64'(tx_out), 64'd0);
        check_val("ar_dout", 64'(data_out), 64'd0);
        check_val("ar_sort", 64'(sort_finish), 64'd0);
        check_val("ar_tos", 64'(top_of_stack), 64'd0);
        tick(1);
        f_layer = 1'b1;
        rst_n   = 1'b1;
        exp_q.push_back(mk_frame(4'h0, 4'h1, 4'h2));
        tick(1);
        check_val("ar_restart_tx", 64'(tx_out), 64'd1);
        check_val("ar_restart_id", 64'(chip_id), 64'd1);
        tick(1);
        check_val("ar_restart_ack", 64'(tx_out), 64'd0);
        rst_n = 1'b0;

        check_val("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
